// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward generation plus a memory-wait FSM with a watchdog.
// Optional macro HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module pl_hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  Result_srcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        PCSrcE,
    input  logic        mem_busy,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {
        S_RUN,
        S_MEMWAIT
    } state_t;

    localparam logic [1:0]        FWD_RF  = 2'b00;
    localparam logic [1:0]        FWD_W   = 2'b01;
    localparam logic [1:0]        FWD_M   = 2'b10;
    localparam logic [1:0]        RES_LD  = 2'b01;
    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] ONE_CNT = WAIT_W'(1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;

    logic               lw_stall;
    logic               freeze;
    logic               stall_fd, stall_em;
    logic               flush_d_raw, flush_e_raw;
    logic [1:0]         fwd_a, fwd_b;

    // M has priority over W because it holds the younger result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(Rs1E, regwriteM, RdM, regwriteW, RdW);
        fwd_b = fwd_sel(Rs2E, regwriteM, RdM, regwriteW, RdW);
    end

    always_comb begin
        lw_stall = (Result_srcE == RES_LD) && (RdE != 5'd0) &&
                   ((Rs1D == RdE) || (Rs2D == RdE));
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        freeze     = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    state_d    = S_MEMWAIT;
                    wait_cnt_d = ONE_CNT;
                end
            end
            S_MEMWAIT: begin
                if (mem_busy) begin
                    freeze = 1'b1;
                    if (wait_cnt_q != MAX_CNT) begin
                        wait_cnt_d = wait_cnt_q + ONE_CNT;
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (mem_busy && (wait_cnt_d == MAX_CNT)) begin
            timeout_d = 1'b1;
        end
    end

    // A freeze beats every flush; a taken branch squashes D so it overrides the load-use hold.
    always_comb begin
        if (freeze) begin
            stall_fd    = 1'b1;
            stall_em    = 1'b1;
            flush_d_raw = 1'b0;
            flush_e_raw = 1'b0;
        end else begin
            stall_fd    = lw_stall && !PCSrcE;
            stall_em    = 1'b0;
            flush_d_raw = PCSrcE;
            flush_e_raw = PCSrcE || lw_stall;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // While in reset the pipeline registers are held cleared and nothing is stalled.
    always_comb begin
        StallF      = reset_n && stall_fd;
        StallD      = reset_n && stall_fd;
        StallE      = reset_n && stall_em;
        StallM      = reset_n && stall_em;
        FlushD      = !reset_n || flush_d_raw;
        FlushE      = !reset_n || flush_e_raw;
        ForwardAE   = reset_n ? fwd_a : FWD_RF;
        ForwardBE   = reset_n ? fwd_b : FWD_RF;
        mem_timeout = timeout_q;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, StallD};
        flush_cnt_d = flush_cnt_q + {31'd0, FlushD};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Self-checking bench for pl_hazard_ctrl: a reference model pushes expected outputs to a scoreboard queue.
module tb_pl_hazard_ctrl;

    localparam int MAX_WAIT = 8;
    localparam int WAIT_W   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic [1:0]  Result_srcE = '0;
    logic        regwriteM = 1'b0, regwriteW = 1'b0, PCSrcE = 1'b0, mem_busy = 1'b0;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] stall_cycles, flush_count;

    pl_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .Result_srcE(Result_srcE), .RdM(RdM), .RdW(RdW),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .PCSrcE(PCSrcE), .mem_busy(mem_busy),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] vec;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Reference model state
    bit    m_frozen = 1'b0;
    int    m_cnt = 0;
    bit    m_timeout = 1'b0;
    int    m_stalls = 0;
    int    m_flushes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (regwriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (regwriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Vector order: StallF StallD StallE StallM FlushD FlushE ForwardAE ForwardBE mem_timeout
    function automatic logic [10:0] model_out();
        bit lw;
        bit sf, se, fd, fe;
        lw = (Result_srcE == 2'b01) && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        if (mem_busy) begin
            sf = 1; se = 1; fd = 0; fe = 0;
        end else begin
            sf = lw && !PCSrcE; se = 0; fd = PCSrcE; fe = PCSrcE || lw;
        end
        return {sf, sf, se, se, fd, fe, model_fwd(Rs1E), model_fwd(Rs2E), m_timeout};
    endfunction

    function automatic logic [10:0] dut_out();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, mem_timeout};
    endfunction

    // Inputs are set at posedge+1; outputs are sampled at posedge+3.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.vec = model_out();
        sb_q.push_back(e);
        #2;
        got = sb_q.pop_front();
        check(got.tag, {21'd0, dut_out()}, {21'd0, got.vec});
        if (got.vec[9]) m_stalls++;
        if (got.vec[6]) m_flushes++;
        if (!m_frozen) begin
            if (mem_busy) begin
                m_frozen = 1;
                m_cnt = 1;
            end
        end else if (mem_busy) begin
            if (m_cnt < MAX_WAIT) m_cnt++;
        end else begin
            m_frozen = 0;
            m_cnt = 0;
        end
        if (mem_busy && m_cnt == MAX_WAIT) m_timeout = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        Result_srcE = 0; regwriteM = 0; regwriteW = 0; PCSrcE = 0; mem_busy = 0;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        exp_t got;
        #1;
        reset_n = 1'b0;
        #1;
        e.tag = tag;
        e.vec = 11'b0000_11_00_00_0;
        sb_q.push_back(e);
        got = sb_q.pop_front();
        check(got.tag, {21'd0, dut_out()}, {21'd0, got.vec});
        check({tag, "_stall_cnt"}, stall_cycles, 32'd0);
        check({tag, "_flush_cnt"}, flush_count, 32'd0);
        m_frozen = 0; m_cnt = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Load-use: one bubble, then clears once E no longer holds the load.
        Result_srcE = 2'b01; RdE = 5; Rs1D = 5;
        step("lw_stall");
        RdE = 0;
        step("lw_clear");
        Result_srcE = 2'b01; RdE = 9; Rs2D = 9; Rs1D = 0;
        step("lw_rs2");
        RdE = 0; Rs2D = 0; Rs1D = 0;
        step("lw_x0");
        clear_inputs();

        // Forwarding priority and x0 exclusion.
        regwriteM = 1; regwriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 0;
        step("fwd_m_prio");
        RdM = 3;
        step("fwd_w");
        Rs2E = 3;
        step("fwd_b_m");
        regwriteM = 0;
        step("fwd_m_nowrite");
        RdW = 0; Rs1E = 0;
        step("fwd_x0");
        clear_inputs();

        // Taken branch overrides load-use.
        Result_srcE = 2'b01; RdE = 5; Rs1D = 5; PCSrcE = 1;
        step("br_over_lw");
        clear_inputs();
        step("idle0");

        // Memory wait with a branch pending in E.
        PCSrcE = 1; mem_busy = 1;
        for (int i = 0; i < 4; i++) step($sformatf("memwait_br_%0d", i));
        mem_busy = 0;
        step("memwait_release");
        PCSrcE = 0;
        step("memwait_after");

        // Watchdog: 10 busy cycles, timeout rises after the 8th and stays sticky.
        mem_busy = 1;
        for (int i = 0; i < 10; i++) step($sformatf("timeout_busy_%0d", i));
        mem_busy = 0;
        step("timeout_drop");
        step("timeout_sticky");
        mem_busy = 1;
        step("rebusy0");
        step("rebusy1");
        do_reset("reset_mid_wait");
        step("post_reset_busy");
        mem_busy = 0;
        step("post_reset_idle");
        do_reset("reset_perf");

        // Performance counters: 3 load-use stalls and 2 taken branches.
        for (int i = 0; i < 3; i++) begin
            Result_srcE = 2'b01; RdE = 5'(i + 1); Rs1D = 5'(i + 1);
            step($sformatf("perf_lw_%0d", i));
            clear_inputs();
            step($sformatf("perf_gap_%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            PCSrcE = 1;
            step($sformatf("perf_br_%0d", i));
            PCSrcE = 0;
            step($sformatf("perf_brgap_%0d", i));
        end
`ifdef HAZARD_PERF_EN
        check("perf_model_stalls", 32'(m_stalls), 32'd3);
        check("perf_model_flushes", 32'(m_flushes), 32'd2);
        check("stall_cycles", stall_cycles, 32'd3);
        check("flush_count", flush_count, 32'd2);
`else
        check("stall_cycles_off", stall_cycles, 32'd0);
        check("flush_count_off", flush_count, 32'd0);
`endif
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
